// File: rtl/bitrec_pkg.sv
// Shared types and constants for the bit recovery / frame deserializer chain.
package bitrec_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_e;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;
    localparam logic [15:0] FREQ_IDLE_DEF = 16'd801;

    // Magnitude of an unsigned difference without a sign bit.
    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/bit_frame_deserializer_line_sampler.sv
// Line front end: 2-flop synchroniser on the serial line plus rising-edge
// detect on the recovered clock; emits a one-cycle sample strobe and the bit.
module line_sampler (
    input  logic clk_200M,
    input  logic rst,
    input  logic sig_i,
    input  logic rec_i,
    output logic smp_o,
    output logic bit_o
);

    logic sig_meta_q;
    logic sig_s_q;
    logic rec_d_q;

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            sig_meta_q <= 1'b0;
            sig_s_q    <= 1'b0;
            rec_d_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value;
            // blocking here would collapse the synchroniser into a single stage.
            sig_meta_q <= sig_i;
            sig_s_q    <= sig_meta_q;
            rec_d_q    <= rec_i;
        end
    end

    assign smp_o = rec_i & ~rec_d_q;
    assign bit_o = sig_s_q;

endmodule

// File: rtl/bit_frame_deserializer.sv
// Sync-word hunter and MSB-first byte assembler with valid/ready output.
// Optional INVERT_DETECT_EN: also lock on the complemented sync word and invert data.
module bit_frame_deserializer
    import bitrec_pkg::*;
#(
    parameter int unsigned       SYNC_W      = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD   = SYNC_W'(SYNC_WORD_DEF),
    parameter int unsigned       FRAME_BYTES = 16,
    parameter int unsigned       FREQ_TOL    = 4,
    parameter logic [15:0]       FREQ_IDLE   = FREQ_IDLE_DEF
) (
    input  logic        clk_200M,
    input  logic        rst,
    input  logic        signal,
    input  logic        clk_rec,
    input  logic [15:0] clk_freq,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        locked,
    output logic        frame_done,
    output logic        lock_lost,
    output logic        overflow
);

    localparam logic [7:0]  LAST_BYTE = 8'(FRAME_BYTES - 1);
    localparam logic [15:0] TOL       = 16'(FREQ_TOL);

    logic smp;
    logic bit_s;

    line_sampler u_line_sampler (
        .clk_200M (clk_200M),
        .rst      (rst),
        .sig_i    (signal),
        .rec_i    (clk_rec),
        .smp_o    (smp),
        .bit_o    (bit_s)
    );

    state_e            state_q,      state_d;
    logic [SYNC_W-1:0] sync_sr_q,    sync_sr_d;
    logic [15:0]       freq_ref_q,   freq_ref_d;
    logic [2:0]        bit_cnt_q,    bit_cnt_d;
    logic [7:0]        byte_cnt_q,   byte_cnt_d;
    logic [7:0]        byte_sr_q,    byte_sr_d;
    logic              byte_rdy_q,   byte_rdy_d;
    logic [7:0]        data_out_q,   data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              lock_lost_q,  lock_lost_d;
    logic              overflow_q,   overflow_d;

    logic              inv_q;
    logic              match_pos;
    logic              match_inv;
    logic              drift;
    logic              data_bit;
    logic [SYNC_W-1:0] sync_next;

    assign sync_next = {sync_sr_q[SYNC_W-2:0], bit_s};
    assign match_pos = (sync_next == SYNC_WORD);
    assign drift     = (state_q == DATA) && (abs_diff(clk_freq, freq_ref_q) > TOL);
    assign data_bit  = bit_s ^ inv_q;

`ifdef INVERT_DETECT_EN
    logic inv_d;
    assign match_inv = (sync_next == ~SYNC_WORD);
`else
    assign inv_q     = 1'b0;
    assign match_inv = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state value takes its hold/default first so no path
        // leaves a variable unassigned (which would infer a latch).
        state_d      = state_q;
        sync_sr_d    = sync_sr_q;
        freq_ref_d   = freq_ref_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        byte_sr_d    = byte_sr_q;
        byte_rdy_d   = 1'b0;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        frame_done_d = 1'b0;
        lock_lost_d  = 1'b0;
        overflow_d   = overflow_q;
`ifdef INVERT_DETECT_EN
        inv_d        = inv_q;
`endif

        // Consumer took the held byte; a new offer below overrides this.
        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        unique case (state_q)
            HUNT: begin
                if (smp) begin
                    if ((match_pos || match_inv) && (clk_freq < FREQ_IDLE)) begin
                        state_d    = DATA;
                        freq_ref_d = clk_freq;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 8'd0;
                        sync_sr_d  = '0;
`ifdef INVERT_DETECT_EN
                        inv_d      = match_inv && !match_pos;
`endif
                    end else begin
                        sync_sr_d = sync_next;
                    end
                end
            end

            DATA: begin
                if (drift) begin
                    // Drift takes priority over a byte completing in the same cycle.
                    state_d     = HUNT;
                    lock_lost_d = 1'b1;
                    bit_cnt_d   = 3'd0;
`ifdef INVERT_DETECT_EN
                    inv_d       = 1'b0;
`endif
                end else begin
                    if (smp) begin
                        byte_sr_d = {byte_sr_q[6:0], data_bit};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_rdy_d = 1'b1;
                        end
                    end

                    if (byte_rdy_q) begin
                        if (!data_valid_q || data_ready) begin
                            data_out_d   = byte_sr_q;
                            data_valid_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end

                        if (byte_cnt_q == LAST_BYTE) begin
                            frame_done_d = 1'b1;
                            state_d      = HUNT;
                            byte_cnt_d   = 8'd0;
`ifdef INVERT_DETECT_EN
                            inv_d        = 1'b0;
`endif
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end
                end
            end

            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            state_q      <= HUNT;
            sync_sr_q    <= '0;
            freq_ref_q   <= 16'd0;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 8'd0;
            byte_sr_q    <= 8'd0;
            byte_rdy_q   <= 1'b0;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            lock_lost_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_sr_q    <= sync_sr_d;
            freq_ref_q   <= freq_ref_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            byte_sr_q    <= byte_sr_d;
            byte_rdy_q   <= byte_rdy_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_done_q <= frame_done_d;
            lock_lost_q  <= lock_lost_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef INVERT_DETECT_EN
    always_ff @(posedge clk_200M) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end
`endif

    assign locked     = (state_q == DATA);
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_done = frame_done_q;
    assign lock_lost  = lock_lost_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bit_frame_deserializer.sv
// Self-checking bench: directed scenarios plus randomized frames scored against
// a bit-stream reference model (sync search + byte grouping).
module tb_bit_frame_deserializer;

    typedef logic [7:0] bq_t [$];
    typedef bit         bitq_t [$];

    localparam logic [15:0] SYNC = 16'hA55A;

    logic        clk_200M = 1'b0;
    logic        rst = 1'b1;
    logic        signal = 1'b0;
    logic        clk_rec = 1'b0;
    logic        data_ready = 1'b1;
    logic [15:0] clk_freq = 16'd40;

    logic [7:0]  data_out,   data_out2;
    logic        data_valid, data_valid2;
    logic        locked,     locked2;
    logic        frame_done, frame_done2;
    logic        lock_lost,  lock_lost2;
    logic        overflow,   overflow2;

    always #5 clk_200M = ~clk_200M;

    bit_frame_deserializer dut (
        .clk_200M   (clk_200M),
        .rst        (rst),
        .signal     (signal),
        .clk_rec    (clk_rec),
        .clk_freq   (clk_freq),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .locked     (locked),
        .frame_done (frame_done),
        .lock_lost  (lock_lost),
        .overflow   (overflow)
    );

    bit_frame_deserializer #(.FRAME_BYTES(2)) dut2 (
        .clk_200M   (clk_200M),
        .rst        (rst),
        .signal     (signal),
        .clk_rec    (clk_rec),
        .clk_freq   (clk_freq),
        .data_out   (data_out2),
        .data_valid (data_valid2),
        .data_ready (data_ready),
        .locked     (locked2),
        .frame_done (frame_done2),
        .lock_lost  (lock_lost2),
        .overflow   (overflow2)
    );

    int tests_run = 0;
    int fails     = 0;

    bq_t   got1, got2;
    bitq_t stream_q;
    logic       pend_v1, pend_v2;
    logic [7:0] pend_o1, pend_o2;
    int valid_cyc1, fd_cnt1, fd_cnt2, fd_with_valid2, ll_cnt1, unstable1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input bq_t got, input bq_t exp);
        check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    // Reference: scan the bit stream for the sync word, then group MSB-first bytes
    // until the frame is full; after a full frame the hunt restarts on fresh bits.
    function automatic bq_t model_bytes(input bitq_t bits, input int fb, input bit freq_ok);
        bq_t         res;
        int          hunt_start;
        int          i;
        int          j;
        int          nb;
        logic [15:0] w;
        logic [7:0]  v;
        hunt_start = 0;
        i = 0;
        while (i < bits.size()) begin
            if (freq_ok && (i - hunt_start >= 15)) begin
                w = '0;
                for (int k = i - 15; k <= i; k++) w = {w[14:0], bits[k]};
                if (w == SYNC) begin
                    nb = 0;
                    j = i + 1;
                    while (nb < fb && j + 7 < bits.size()) begin
                        v = '0;
                        for (int k = 0; k < 8; k++) v = {v[6:0], bits[j+k]};
                        res.push_back(v);
                        j += 8;
                        nb++;
                    end
                    if (nb < fb) return res;
                    hunt_start = j;
                    i = j;
                    continue;
                end
            end
            i++;
        end
        return res;
    endfunction

    // One clock: score the handshake that happened at the posedge just passed,
    // then capture the current outputs for the next one.
    task automatic tick();
        @(negedge clk_200M);
        if (pend_v1 && data_ready) got1.push_back(pend_o1);
        if (pend_v1 && !data_ready && data_out !== pend_o1) unstable1++;
        if (pend_v2 && data_ready) got2.push_back(pend_o2);
        pend_v1 = data_valid;
        pend_o1 = data_out;
        pend_v2 = data_valid2;
        pend_o2 = data_out2;
        if (data_valid) valid_cyc1++;
        if (frame_done) fd_cnt1++;
        if (lock_lost)  ll_cnt1++;
        if (frame_done2) begin
            fd_cnt2++;
            if (data_valid2) fd_with_valid2++;
        end
    endtask

    task automatic clear_obs();
        got1.delete();
        got2.delete();
        stream_q.delete();
        pend_v1 = 1'b0; pend_v2 = 1'b0; pend_o1 = '0; pend_o2 = '0;
        valid_cyc1 = 0; fd_cnt1 = 0; fd_cnt2 = 0; fd_with_valid2 = 0;
        ll_cnt1 = 0; unstable1 = 0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) tick();
        signal = 1'b0;
        clk_rec = 1'b0;
        data_ready = 1'b1;
        repeat (2) tick();
        check({tag, "_reset_outs"},
              32'({data_out, data_valid, locked, frame_done, lock_lost, overflow}), 32'd0);
        rst = 1'b0;
        clear_obs();
        tick();
    endtask

    task automatic send_bit(input bit b);
        signal = b;
        stream_q.push_back(b);
        clk_rec = 1'b0;
        repeat (20) tick();
        clk_rec = 1'b1;
        repeat (20) tick();
        clk_rec = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) send_bit(v[i]);
    endtask

    initial begin
        bq_t         exp_q;
        logic [7:0]  b0, b1, b2;
        logic [15:0] f;
        int          n;

        clear_obs();

        // 1: basic lock and two bytes
        do_reset("t1");
        clk_freq = 16'd40;
        for (int i = 15; i >= 1; i--) send_bit(SYNC[i]);
        check("t1_locked_before_last_sync_bit", 32'(locked), 32'd0);
        send_bit(SYNC[0]);
        check("t1_locked_after_sync", 32'(locked), 32'd1);
        send_byte(8'h3C);
        send_byte(8'h81);
        repeat (10) tick();
        exp_q = {8'h3C, 8'h81};
        check_q("t1_bytes", got1, exp_q);
        check("t1_valid_cycles", 32'(valid_cyc1), 32'd2);
        check("t1_still_locked", 32'(locked), 32'd1);
        check("t1_no_frame_done", 32'(fd_cnt1), 32'd0);

        // 2: idle period estimate inhibits lock
        do_reset("t2");
        clk_freq = 16'd801;
        send_word(SYNC);
        send_byte(8'h3C);
        send_byte(8'h81);
        repeat (10) tick();
        check("t2_not_locked", 32'(locked), 32'd0);
        check("t2_no_valid", 32'(valid_cyc1), 32'd0);

        // 3: frame of 2 bytes on dut2, third byte ignored
        do_reset("t3");
        clk_freq = 16'd40;
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        send_word(SYNC);
        send_byte(b0);
        send_byte(b1);
        check("t3_unlocked_after_frame", 32'(locked2), 32'd0);
        send_byte(b2);
        repeat (10) tick();
        exp_q = {b0, b1};
        check_q("t3_frame_bytes", got2, exp_q);
        check("t3_frame_done_count", 32'(fd_cnt2), 32'd1);
        check("t3_frame_done_with_valid", 32'(fd_with_valid2), 32'd1);
        exp_q = {b0, b1, b2};
        check_q("t3_long_frame_bytes", got1, exp_q);

        // 4: backpressure -> hold, overflow, then mid-frame reset
        do_reset("t4");
        clk_freq = 16'd40;
        data_ready = 1'b0;
        b0 = 8'($urandom); b1 = ~b0;
        send_word(SYNC);
        send_byte(b0);
        check("t4_valid_first", 32'(data_valid), 32'd1);
        check("t4_out_first", 32'(data_out), 32'(b0));
        check("t4_no_overflow_yet", 32'(overflow), 32'd0);
        send_byte(b1);
        check("t4_out_held", 32'(data_out), 32'(b0));
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_stable", 32'(unstable1), 32'd0);
        data_ready = 1'b1;
        repeat (2) tick();
        exp_q = {b0};
        check_q("t4_accepted", got1, exp_q);
        check("t4_valid_cleared", 32'(data_valid), 32'd0);
        check("t4_overflow_sticky", 32'(overflow), 32'd1);
        data_ready = 1'b0;
        send_byte(8'h5E);
        check("t4_valid_before_rst", 32'(data_valid), 32'd1);
        do_reset("t4_midframe");

        // 5a: drift beyond tolerance mid-byte
        clk_freq = 16'd40;
        send_word(SYNC);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        clk_freq = 16'd45;
        repeat (5) tick();
        check("t5a_lock_lost_pulse", 32'(ll_cnt1), 32'd1);
        check("t5a_unlocked", 32'(locked), 32'd0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        repeat (5) tick();
        check("t5a_no_partial_byte", 32'(valid_cyc1), 32'd0);

        // 5b: drift exactly at tolerance keeps lock
        do_reset("t5b");
        clk_freq = 16'd40;
        send_word(SYNC);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        clk_freq = 16'd44;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        repeat (5) tick();
        check("t5b_locked", 32'(locked), 32'd1);
        check("t5b_no_lock_lost", 32'(ll_cnt1), 32'd0);
        exp_q = {8'hA6};
        check_q("t5b_byte", got1, exp_q);

        // 6: inverted sync word
        do_reset("t6");
        clk_freq = 16'd40;
        send_word(~SYNC);
        send_byte(8'hC3);
        repeat (5) tick();
`ifdef INVERT_DETECT_EN
        check("t6_locked", 32'(locked), 32'd1);
        exp_q = {8'h3C};
`else
        check("t6_locked", 32'(locked), 32'd0);
        exp_q = {};
`endif
        check_q("t6_bytes", got1, exp_q);

        // Randomized frames against the stream model
        for (int it = 0; it < 4; it++) begin
            do_reset($sformatf("rnd%0d", it));
            f = 16'($urandom_range(20, 900));
            clk_freq = f;
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) send_bit(1'($urandom));
            send_word(SYNC);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) send_byte(8'($urandom));
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) send_bit(1'($urandom));
            repeat (10) tick();
            check_q($sformatf("rnd%0d_f16", it), got1, model_bytes(stream_q, 16, f < 16'd801));
            check_q($sformatf("rnd%0d_f2", it), got2, model_bytes(stream_q, 2, f < 16'd801));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
